// File: rtl/micro_pkg.sv
// Shared definitions for the microprogram sequencer.
// Holds the next-state select and condition select encodings, the MIPS
// opcode/funct values recognised by the dispatch table, the microstore
// entry points each instruction dispatches to, and the fixed entry states.
package micro_pkg;

    // Next-state select field of the microword
    typedef enum logic [2:0] {
        NS_DISPATCH = 3'b000,
        NS_FETCH    = 3'b001,
        NS_JUMP     = 3'b010,
        NS_INC      = 3'b011,
        NS_CJUMP    = 3'b100,
        NS_CWAIT    = 3'b101,
        NS_CRET     = 3'b110,
        NS_RESET    = 3'b111
    } nsel_e;

    // Datapath condition select field of the microword
    typedef enum logic [1:0] {
        CS_MOC   = 2'b00,
        CS_ALU_Z = 2'b01,
        CS_ALU_N = 2'b10,
        CS_ONE   = 2'b11
    } csel_e;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // R-type function codes (ir[5:0])
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_JR   = 6'h08;

    // Fixed microstore entry points
    localparam logic [6:0] ST_RESET = 7'd0;
    localparam logic [6:0] ST_FETCH = 7'd1;

    // Dispatch targets
    localparam logic [6:0] ST_ADDU  = 7'd6;
    localparam logic [6:0] ST_LW    = 7'd7;
    localparam logic [6:0] ST_SW    = 7'd12;
    localparam logic [6:0] ST_LUI   = 7'd16;
    localparam logic [6:0] ST_SUBU  = 7'd17;
    localparam logic [6:0] ST_ADDIU = 7'd18;
    localparam logic [6:0] ST_AND   = 7'd19;
    localparam logic [6:0] ST_OR    = 7'd21;
    localparam logic [6:0] ST_SLT   = 7'd23;
    localparam logic [6:0] ST_JR    = 7'd30;
    localparam logic [6:0] ST_BEQ   = 7'd34;
    localparam logic [6:0] ST_BNE   = 7'd35;
    localparam logic [6:0] ST_J     = 7'd36;
    localparam logic [6:0] ST_JAL   = 7'd37;

endpackage

// File: rtl/opcode_dispatch.sv
// Combinational instruction decoder for the sequencer's dispatch source.
// Ports:
//   opcode  in  6  ir[31:26]
//   funct   in  6  ir[5:0], only meaningful for R-type
//   valid   out 1  1 when the opcode/funct pair has a microcode routine
//   target  out 7  microstore entry point of that routine (0 when invalid)
module opcode_dispatch
    import micro_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       valid,
    output logic [6:0] target
);

    // Opcode/funct lookup; anything unlisted is reported invalid
    always_comb begin
        valid  = 1'b1;
        target = ST_RESET;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: target = ST_ADDU;
                    FN_SUBU: target = ST_SUBU;
                    FN_AND:  target = ST_AND;
                    FN_OR:   target = ST_OR;
                    FN_SLT:  target = ST_SLT;
                    FN_JR:   target = ST_JR;
                    default: valid  = 1'b0;
                endcase
            end
            OP_LW:    target = ST_LW;
            OP_SW:    target = ST_SW;
            OP_LUI:   target = ST_LUI;
            OP_ADDIU: target = ST_ADDIU;
            OP_BEQ:   target = ST_BEQ;
            OP_BNE:   target = ST_BNE;
            OP_J:     target = ST_J;
            OP_JAL:   target = ST_JAL;
            default:  valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Next-state controller of the microprogrammed control unit.
// Holds the current microstate and picks the next one from opcode dispatch,
// the microword jump target, increment or hold, steered by n_sel and a
// selectable (optionally inverted) datapath condition. Waits on a condition
// (CWAIT) are bounded: after MOC_TIMEOUT held cycles the sequencer traps.
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   n_sel, inv, cond_sel microword next-state select / condition controls
//   cr                   microword jump target
//   moc, alu_z, alu_n    datapath conditions
//   ir                   instruction register
//   state                current microstate (microstore address)
//   moc_timeout          one-cycle pulse when a condition wait expires
//   illegal_op           one-cycle pulse when dispatch finds no routine
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int                 STATE_W     = 7,
    parameter int                 MOC_TIMEOUT = 15,
    parameter logic [STATE_W-1:0] TRAP_STATE  = 7'd1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         n_sel,
    input  logic               inv,
    input  logic [1:0]         cond_sel,
    input  logic [6:0]         cr,
    input  logic               moc,
    input  logic               alu_z,
    input  logic               alu_n,
    input  logic [31:0]        ir,
    output logic [STATE_W-1:0] state,
    output logic               moc_timeout,
    output logic               illegal_op
);

    localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               moc_timeout_q, moc_timeout_d;
    logic               illegal_op_q, illegal_op_d;

    logic               cond_raw_s;
    logic               cond_s;
    logic               disp_valid_s;
    logic [6:0]         disp_target_s;
    logic [STATE_W-1:0] state_inc_s;
    logic               unused_ir_s;

    // Only opcode and funct steer dispatch; the operand fields are ignored
    assign unused_ir_s = ^ir[25:6];

    opcode_dispatch u_dispatch (
        .opcode (ir[31:26]),
        .funct  (ir[5:0]),
        .valid  (disp_valid_s),
        .target (disp_target_s)
    );

    // Natural-width add wraps the top state back to 0
    assign state_inc_s = state_q + STATE_W'(1);

    // Condition source mux followed by optional inversion
    always_comb begin
        cond_raw_s = 1'b0;
        case (csel_e'(cond_sel))
            CS_MOC:   cond_raw_s = moc;
            CS_ALU_Z: cond_raw_s = alu_z;
            CS_ALU_N: cond_raw_s = alu_n;
            CS_ONE:   cond_raw_s = 1'b1;
            default:  cond_raw_s = 1'b0;
        endcase
        cond_s = cond_raw_s ^ inv;
    end

    // Next-state selection, wait counting and pulse generation
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        moc_timeout_d = 1'b0;
        illegal_op_d  = 1'b0;
        case (nsel_e'(n_sel))
            NS_DISPATCH: begin
                if (disp_valid_s) begin
                    state_d = STATE_W'(disp_target_s);
                end else begin
                    state_d      = TRAP_STATE;
                    illegal_op_d = 1'b1;
                end
            end
            NS_FETCH: state_d = STATE_W'(ST_FETCH);
            NS_JUMP:  state_d = STATE_W'(cr);
            NS_INC:   state_d = state_inc_s;
            NS_CJUMP: begin
                if (cond_s) begin
                    state_d = STATE_W'(cr);
                end else begin
                    state_d = state_inc_s;
                end
            end
            NS_CWAIT: begin
                // The condition is checked first so that it wins a tie
                // with an expiring counter.
                if (cond_s) begin
                    state_d = state_inc_s;
                end else if (wait_cnt_q == CNT_W'(MOC_TIMEOUT)) begin
                    state_d       = TRAP_STATE;
                    moc_timeout_d = 1'b1;
                end else begin
                    state_d    = state_q;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            NS_CRET: begin
                if (cond_s) begin
                    state_d = STATE_W'(cr);
                end else begin
                    state_d = STATE_W'(ST_FETCH);
                end
            end
            NS_RESET: state_d = STATE_W'(ST_RESET);
            default:  state_d = STATE_W'(ST_RESET);
        endcase
    end

    // State, wait counter and status pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= STATE_W'(ST_RESET);
            wait_cnt_q    <= '0;
            moc_timeout_q <= 1'b0;
            illegal_op_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            moc_timeout_q <= moc_timeout_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    assign state       = state_q;
    assign moc_timeout = moc_timeout_q;
    assign illegal_op  = illegal_op_q;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Next-state controller for the microprogrammed control unit.
- Holds the 7-bit current microstate and drives the microstore address input.
- Each cycle it selects the next microstate from one of four sources: opcode dispatch, microword jump target, increment, or hold.
- Selection is steered by microword fields and a selectable datapath condition, with a bounded wait on memory-operation-complete (MOC).

Parameters:
- STATE_W, 7, microstate width.
- MOC_TIMEOUT, 15, maximum consecutive wait cycles on MOC before a timeout trap.
- TRAP_STATE, 7'd1, state entered on MOC timeout or illegal opcode (the ignore-and-continue state).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- n_sel  in  3  next-state select field from the current microword.
- inv  in  1  inverts the selected condition.
- cond_sel  in  2  condition select: 00 MOC, 01 ALU zero, 10 ALU negative, 11 constant 1.
- cr  in  7  jump target field from the current microword.
- moc  in  1  memory operation complete.
- alu_z  in  1  ALU zero flag.
- alu_n  in  1  ALU negative flag.
- ir  in  32  instruction register.
- state  out  7  current microstate, feeds the microstore currentState input.
- moc_timeout  out  1  one-cycle pulse when a MOC wait expires.
- illegal_op  out  1  one-cycle pulse when dispatch hits an unmapped opcode.

Behaviour:
- Reset (async): state=7'd0, wait counter=0, moc_timeout=0, illegal_op=0. Reset asserted mid-wait aborts the wait immediately.
- On every rising clk edge without reset, state <= next. There is one cycle of latency from the microword fields to the new state.
- Condition: c = selected condition XOR inv.
- n_sel decode:
  - 000 DISPATCH: next = dispatch(ir).
  - 001 FETCH: next = 7'd1.
  - 010 JUMP: next = cr.
  - 011 INC: next = state+1.
  - 100 CJUMP: next = c ? cr : state+1.
  - 101 CWAIT: next = c ? state+1 : state (hold).
  - 110 CRET: next = c ? cr : 7'd1.
  - 111: next = 7'd0.
- Increment wraps: 7'd127+1 = 7'd0.
- Dispatch, R-type (opcode 6'h00), by funct:
  - 6'h21 ADDU -> 7'd6.
  - 6'h23 SUBU -> 7'd17.
  - 6'h24 AND -> 7'd19.
  - 6'h25 OR -> 7'd21.
  - 6'h2A SLT -> 7'd23.
  - 6'h08 JR -> 7'd30.
- Dispatch by opcode:
  - 6'h23 LW -> 7'd7.
  - 6'h2B SW -> 7'd12.
  - 6'h0F LUI -> 7'd16.
  - 6'h09 ADDIU -> 7'd18.
  - 6'h04 BEQ -> 7'd34.
  - 6'h05 BNE -> 7'd35.
  - 6'h02 J -> 7'd36.
  - 6'h03 JAL -> 7'd37.
- Any other opcode/funct: next = TRAP_STATE, and illegal_op pulses in the cycle the transition registers.
- MOC wait counter:
  - Counts cycles spent in CWAIT with c=0. It clears on any other n_sel, or when c=1.
  - When the counter reaches MOC_TIMEOUT while still held: next = TRAP_STATE, moc_timeout pulses for one cycle, counter clears.
  - If c rises in the same cycle the counter reaches MOC_TIMEOUT, the condition wins: next = state+1, no timeout.
- cond_sel=11 with inv=1 gives c=0. In CWAIT this therefore holds until the timeout trap; it is legal and must not lock up.
- Outputs are registered; no output is combinational from the inputs.

Decomposition:
- Shared package micro_pkg holds:
  - n_sel encodings (NS_DISPATCH … NS_RESET);
  - cond_sel encodings;
  - MIPS opcode and funct constants;
  - the named dispatch targets (ST_ADDU=7'd6, etc.);
  - ST_FETCH=7'd1 and ST_RESET=7'd0.
- One sub-module, opcode_dispatch: purely combinational. It maps ir[31:26]/ir[5:0] to {valid, target[6:0]}.
- The sequencer top holds the state register, condition mux, next-state mux and wait counter.

Test Plan:
- Reset then release with n_sel=001 -> state 0 after reset, 1 on the first edge. Assert reset mid-CWAIT -> state 0 immediately, without waiting for a clock edge.
- state=1, n_sel=000, ir=32'h8C220004 (LW) -> state 7 next cycle. ir=32'h00221821 (ADDU) -> 6. ir=32'hFC000000 -> state 1 and an illegal_op pulse.
- n_sel=101, cond_sel=00, inv=0, moc low 3 cycles then high -> state holds 3 cycles, then state+1, and moc_timeout stays 0.
- Same setup with moc never high -> hold 15 cycles, then state=1 with a single moc_timeout pulse. Also moc rising on the 15th cycle -> state+1 and no pulse.
- n_sel=100, cond_sel=01, cr=7'd40: alu_z=1 -> 40, alu_z=0 -> state+1. With inv=1 the outcomes are reversed.
- state=127, n_sel=011 -> 0. n_sel=010, cr=7'd43 -> 43. n_sel=110, c=0 -> 1.
